// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and settle/capture sequencer for the 4-bit ALU
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [4:0] cmd_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_s4,
  output logic       alu_s3,
  output logic       alu_s2,
  output logic       alu_s1,
  output logic       alu_s0,
  input  logic [3:0] alu_o,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_o,
  output logic       rsp_cout,
  output logic [4:0] rsp_sel,
  output logic       busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [12:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [12:0]     head;

  logic            issue;
  logic            capture;
  logic            rsp_clr;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      alu_sel_q;

  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr_q];
  assign busy      = (state_q != IDLE) || !empty;

  assign alu_s4 = alu_sel_q[4];
  assign alu_s3 = alu_sel_q[3];
  assign alu_s2 = alu_sel_q[2];
  assign alu_s1 = alu_sel_q[1];
  assign alu_s0 = alu_sel_q[0];

  // FIFO storage: no reset needed, occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {cmd_a, cmd_b, cmd_sel};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    rsp_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          issue   = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(1)) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_clr = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            issue   = 1'b1;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive registers hold the last issued command until the next issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel_q <= '0;
    end else if (issue) begin
      alu_a     <= head[12:9];
      alu_b     <= head[8:5];
      alu_sel_q <= head[4:0];
    end
  end

  // Settle counter: loaded on issue, counts down while the ALU inputs settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= CW'(SETTLE_CYCLES);
    end else if (state_q == SETTLE) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Response capture; data keeps its last value, rsp_valid alone qualifies it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_o     <= '0;
      rsp_cout  <= 1'b0;
      rsp_sel   <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_o     <= alu_o;
      rsp_cout  <= alu_cout;
      rsp_sel   <= alu_sel_q;
    end else if (rsp_clr) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
